// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position controller: adds signed velocities once every FRAME_DIV
// enabled frames, clamps (or wraps in X) to keep the scaled sprite on screen.
module sprite_motion_ctrl #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int SCREEN_CORDW = 16,
  parameter int SPRITE_W     = 68,
  parameter int SPRITE_H     = 72,
  parameter int X_INIT       = 286,
  parameter int Y_INIT       = 300,
  parameter int VEL_W        = 5,
  parameter int FRAME_DIV    = 1,
  parameter int WRAP_X       = 0
) (
  input  logic                    clk_pix,
  input  logic                    rst_n,
  input  logic                    frame,
  input  logic                    en,
  input  logic [VEL_W-1:0]        vel_x,
  input  logic [VEL_W-1:0]        vel_y,
  input  logic                    load,
  input  logic [SCREEN_CORDW-1:0] load_x,
  input  logic [SCREEN_CORDW-1:0] load_y,
  output logic [SCREEN_CORDW-1:0] pos_x,
  output logic [SCREEN_CORDW-1:0] pos_y,
  output logic                    hit_left,
  output logic                    hit_right,
  output logic                    hit_top,
  output logic                    hit_bottom,
  output logic                    moved
);

  localparam int CW   = SCREEN_CORDW;
  localparam int XMAX = H_RES - SPRITE_W;
  localparam int YMAX = V_RES - SPRITE_H;
  localparam int DW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [CW-1:0]        XMAX_C   = CW'(XMAX);
  localparam logic [CW-1:0]        YMAX_C   = CW'(YMAX);
  localparam logic [CW-1:0]        X_INIT_C = CW'(X_INIT);
  localparam logic [CW-1:0]        Y_INIT_C = CW'(Y_INIT);
  localparam logic signed [CW:0]   XMAX_S   = (CW+1)'(XMAX);
  localparam logic signed [CW:0]   YMAX_S   = (CW+1)'(YMAX);
  localparam logic signed [CW:0]   XSPAN_S  = (CW+1)'(XMAX + 1);
  localparam logic [DW-1:0]        DIV_LAST = DW'(FRAME_DIV - 1);

  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;

  state_t                  state;
  logic [DW-1:0]           div_cnt;
  logic signed [VEL_W-1:0] vx_q, vy_q;
  logic [CW-1:0]           nx, ny;
  logic                    nl, nr, nt, nb;

  logic signed [CW:0]      sum_x, sum_y, wrap_x;
  logic                    x_lo, x_hi, y_lo, y_hi;

  always_comb begin
    sum_x  = $signed({1'b0, pos_x}) + (CW+1)'(vx_q);
    sum_y  = $signed({1'b0, pos_y}) + (CW+1)'(vy_q);
    x_lo   = sum_x < 0;
    x_hi   = sum_x > XMAX_S;
    y_lo   = sum_y < 0;
    y_hi   = sum_y > YMAX_S;
    wrap_x = sum_x;
    if (x_lo)      wrap_x = sum_x + XSPAN_S;
    else if (x_hi) wrap_x = sum_x - XSPAN_S;
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      vx_q       <= '0;
      vy_q       <= '0;
      nx         <= '0;
      ny         <= '0;
      nl         <= 1'b0;
      nr         <= 1'b0;
      nt         <= 1'b0;
      nb         <= 1'b0;
      pos_x      <= X_INIT_C;
      pos_y      <= Y_INIT_C;
      hit_left   <= 1'b0;
      hit_right  <= 1'b0;
      hit_top    <= 1'b0;
      hit_bottom <= 1'b0;
      moved      <= 1'b0;
    end else begin
      moved <= 1'b0;
      if (!en) div_cnt <= '0;
      // load overrides everything, including a same-cycle frame; the divider is left alone
      if (load) begin
        pos_x      <= (load_x > XMAX_C) ? XMAX_C : load_x;
        pos_y      <= (load_y > YMAX_C) ? YMAX_C : load_y;
        hit_left   <= 1'b0;
        hit_right  <= 1'b0;
        hit_top    <= 1'b0;
        hit_bottom <= 1'b0;
        state      <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (frame && en) begin
              if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                vx_q    <= $signed(vel_x);
                vy_q    <= $signed(vel_y);
                state   <= CALC_X;
              end else begin
                div_cnt <= div_cnt + 1'b1;
              end
            end
          end
          CALC_X: begin
            if (WRAP_X != 0) begin
              nx <= wrap_x[CW-1:0];
              nl <= 1'b0;
              nr <= 1'b0;
            end else begin
              nx <= x_lo ? '0 : (x_hi ? XMAX_C : sum_x[CW-1:0]);
              nl <= x_lo;
              nr <= x_hi;
            end
            state <= CALC_Y;
          end
          CALC_Y: begin
            ny    <= y_lo ? '0 : (y_hi ? YMAX_C : sum_y[CW-1:0]);
            nt    <= y_lo;
            nb    <= y_hi;
            state <= COMMIT;
          end
          COMMIT: begin
            pos_x      <= nx;
            pos_y      <= ny;
            hit_left   <= nl;
            hit_right  <= nr;
            hit_top    <= nt;
            hit_bottom <= nb;
            moved      <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench: a clamping/FRAME_DIV=1 instance and a wrapping/FRAME_DIV=3 instance
// share random stimulus; an arithmetic model predicts each commit and load.
module tb_sprite_motion_ctrl;

  localparam int XMAX = 572;
  localparam int YMAX = 408;
  localparam int XI   = 286;
  localparam int YI   = 300;

  logic        clk = 1'b0;
  logic        rst_n, frame, en, load;
  logic [4:0]  vel_x, vel_y;
  logic [15:0] load_x, load_y;
  logic [15:0] px [2];
  logic [15:0] py [2];
  logic        hl [2], hr [2], ht [2], hb [2], mv [2];

  always #5 clk = ~clk;

  sprite_motion_ctrl dut_a (
    .clk_pix(clk), .rst_n(rst_n), .frame(frame), .en(en), .vel_x(vel_x), .vel_y(vel_y),
    .load(load), .load_x(load_x), .load_y(load_y), .pos_x(px[0]), .pos_y(py[0]),
    .hit_left(hl[0]), .hit_right(hr[0]), .hit_top(ht[0]), .hit_bottom(hb[0]), .moved(mv[0])
  );

  sprite_motion_ctrl #(.WRAP_X(1), .FRAME_DIV(3)) dut_b (
    .clk_pix(clk), .rst_n(rst_n), .frame(frame), .en(en), .vel_x(vel_x), .vel_y(vel_y),
    .load(load), .load_x(load_x), .load_y(load_y), .pos_x(px[1]), .pos_y(py[1]),
    .hit_left(hl[1]), .hit_right(hr[1]), .hit_top(ht[1]), .hit_bottom(hb[1]), .moved(mv[1])
  );

  typedef struct {
    int x, y;
    bit l, r, t, b;
    int cyc;
  } exp_t;
  typedef struct {
    int x, y;
  } ld_t;

  exp_t mq0[$], mq1[$];
  ld_t  lq[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  bit load_seen = 0;

  // reference model state
  int m_x[2], m_y[2], m_div[2];
  int m_divmax[2] = '{1, 3};
  bit m_wrap[2]   = '{0, 1};

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    load_seen <= load && rst_n;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int sv(input logic [4:0] v);
    return v[4] ? int'(v) - 32 : int'(v);
  endfunction

  task automatic step(input int p, input int v, input int mx, input bit wrap,
                      output int np, output bit lo, output bit hi);
    int n = p + v;
    lo = 0; hi = 0; np = n;
    if (n < 0) begin
      if (wrap) np = n + mx + 1;
      else begin np = 0; lo = 1; end
    end else if (n > mx) begin
      if (wrap) np = n - (mx + 1);
      else begin np = mx; hi = 1; end
    end
  endtask

  task automatic model_frame(input int i, input bit e, input int vx, input int vy,
                             input int c, input bit commit, output bit started);
    exp_t ex;
    started = 0;
    if (!e) begin m_div[i] = 0; return; end
    if (m_div[i] < m_divmax[i] - 1) begin m_div[i]++; return; end
    m_div[i] = 0;
    started  = 1;
    if (!commit) return;
    step(m_x[i], vx, XMAX, m_wrap[i], ex.x, ex.l, ex.r);
    step(m_y[i], vy, YMAX, 1'b0, ex.y, ex.t, ex.b);
    ex.cyc = c + 4;
    m_x[i] = ex.x;
    m_y[i] = ex.y;
    if (i == 0) mq0.push_back(ex);
    else        mq1.push_back(ex);
  endtask

  task automatic model_load(input int lx, input int ly);
    ld_t l;
    l.x = (lx > XMAX) ? XMAX : lx;
    l.y = (ly > YMAX) ? YMAX : ly;
    for (int i = 0; i < 2; i++) begin m_x[i] = l.x; m_y[i] = l.y; end
    lq.push_back(l);
  endtask

  // monitor
  int s_x[2], s_y[2];
  int s_f[2];
  always @(negedge clk) begin
    ld_t  l;
    exp_t e;
    bit   have_l;
    have_l = 0;
    if (rst_n && load_seen) begin
      if (lq.size() == 0) chk("load_queue_empty", 1, 0);
      else begin l = lq.pop_front(); have_l = 1; end
    end
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk($sformatf("rst_x%0d", i), int'(px[i]), XI);
        chk($sformatf("rst_y%0d", i), int'(py[i]), YI);
        chk($sformatf("rst_flags%0d", i), int'({hl[i], hr[i], ht[i], hb[i], mv[i]}), 0);
        s_x[i] = XI; s_y[i] = YI; s_f[i] = 0;
      end else if (load_seen) begin
        if (have_l) begin
          chk($sformatf("load_x%0d", i), int'(px[i]), l.x);
          chk($sformatf("load_y%0d", i), int'(py[i]), l.y);
          chk($sformatf("load_flags%0d", i), int'({hl[i], hr[i], ht[i], hb[i], mv[i]}), 0);
          s_x[i] = l.x; s_y[i] = l.y; s_f[i] = 0;
        end
      end else if (mv[i]) begin
        if ((i == 0 && mq0.size() == 0) || (i == 1 && mq1.size() == 0)) begin
          chk($sformatf("unexpected_moved%0d", i), 1, 0);
        end else begin
          e = (i == 0) ? mq0.pop_front() : mq1.pop_front();
          chk($sformatf("move_x%0d", i), int'(px[i]), e.x);
          chk($sformatf("move_y%0d", i), int'(py[i]), e.y);
          chk($sformatf("move_hits%0d", i), int'({hl[i], hr[i], ht[i], hb[i]}),
              int'({e.l, e.r, e.t, e.b}));
          chk($sformatf("move_latency%0d", i), cyc, e.cyc);
          s_x[i] = e.x; s_y[i] = e.y; s_f[i] = int'({e.l, e.r, e.t, e.b});
        end
      end else begin
        chk($sformatf("hold_x%0d", i), int'(px[i]), s_x[i]);
        chk($sformatf("hold_y%0d", i), int'(py[i]), s_y[i]);
        chk($sformatf("hold_hits%0d", i), int'({hl[i], hr[i], ht[i], hb[i]}), s_f[i]);
      end
    end
  end

  // stimulus tasks; each starts and ends on a falling edge
  task automatic do_frame(input bit e, input logic [4:0] vx, input logic [4:0] vy, input bit spur);
    int c = cyc;
    int target;
    bit st[2];
    en = e; vel_x = vx; vel_y = vy; frame = 1;
    for (int i = 0; i < 2; i++) model_frame(i, e, sv(vx), sv(vy), c, 1'b1, st[i]);
    @(negedge clk);
    frame = 0; vel_x = 5'($urandom); vel_y = 5'($urandom);
    if (spur && st[0] && st[1]) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      frame = 1;
      @(negedge clk);
      frame = 0;
    end
    target = c + 4 + int'($urandom_range(0, 2));
    while (cyc < target) @(negedge clk);
  endtask

  task automatic do_load(input int lx, input int ly);
    load = 1; load_x = 16'(lx); load_y = 16'(ly);
    model_load(lx, ly);
    @(negedge clk);
    load = 0; load_x = 16'($urandom); load_y = 16'($urandom);
  endtask

  task automatic do_abort(input logic [4:0] vx, input logic [4:0] vy, input int lx, input int ly,
                          input int k);
    bit st;
    en = 1; vel_x = vx; vel_y = vy; frame = 1;
    if (k == 0) begin
      do_load(lx, ly);
      frame = 0;
    end else begin
      for (int i = 0; i < 2; i++) model_frame(i, 1'b1, sv(vx), sv(vy), cyc, 1'b0, st);
      @(negedge clk);
      frame = 0;
      repeat (k - 1) @(negedge clk);
      do_load(lx, ly);
    end
    @(negedge clk);
  endtask

  task automatic do_reset_mid(input logic [4:0] vx, input logic [4:0] vy);
    bit st;
    en = 1; vel_x = vx; vel_y = vy; frame = 1;
    @(negedge clk);
    frame = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    #2 rst_n = 0;
    mq0.delete(); mq1.delete(); lq.delete();
    for (int i = 0; i < 2; i++) begin m_x[i] = XI; m_y[i] = YI; m_div[i] = 0; end
    st = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
  endtask

  function automatic int edge_val(input int mx);
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 20));
      1:       return mx - 20 + int'($urandom_range(0, 40));
      2:       return mx + int'($urandom_range(0, 200));
      default: return int'($urandom_range(0, 1000));
    endcase
  endfunction

  initial begin
    rst_n = 0; frame = 0; en = 0; load = 0;
    vel_x = '0; vel_y = '0; load_x = '0; load_y = '0;
    for (int i = 0; i < 2; i++) begin m_x[i] = XI; m_y[i] = YI; m_div[i] = 0; end
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);

    do_frame(1, 5'd3, 5'd0, 0);
    do_frame(1, 5'd0, 5'd0, 0);
    do_load(571, 5);
    do_frame(1, 5'd5, 5'b11000, 0);
    do_frame(1, 5'd0, 5'd0, 0);
    do_frame(0, 5'd1, 5'd1, 0);
    for (int n = 0; n < 6; n++) do_frame(1, 5'd1, 5'd0, 0);
    do_abort(5'd2, 5'd2, 100, 200, 2);
    do_abort(5'd2, 5'd2, 700, 900, 1);
    do_abort(5'd2, 5'd2, 50, 60, 3);
    do_abort(5'd2, 5'd2, 10, 20, 0);

    for (int n = 0; n < 160; n++) begin
      int r = int'($urandom_range(0, 99));
      if (r < 60)
        do_frame($urandom_range(0, 9) != 0, 5'($urandom), 5'($urandom), $urandom_range(0, 3) == 0);
      else if (r < 80)
        do_load(edge_val(XMAX), edge_val(YMAX));
      else if (r < 93)
        do_abort(5'($urandom), 5'($urandom), edge_val(XMAX), edge_val(YMAX),
                 int'($urandom_range(0, 3)));
      else
        do_reset_mid(5'($urandom), 5'($urandom));
    end

    repeat (6) @(negedge clk);
    chk("pending_moves", mq0.size() + mq1.size(), 0);
    chk("pending_loads", lq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got cyc %0d expected completion", cyc);
    $fatal(1);
  end

endmodule
